gain_ctrl_48bit: RTL and testbench

Automatic gain controller closing the loop around the 48-bit digital gain stage. At each frame marker it captures the completed frame's 48-bit peak magnitude and finds its leading-one position with a multi-cycle nibble scan. It then applies attack/decay rules to choose the right-shift that maps the peak into a 16-bit output window. The result drives the gain stage's `scaled_coeff` input and changes only on frame boundaries, so a frame is never requantised mid-stream.

---
 rtl/gain_ctrl_48bit.sv | 176 +++++++++++++++++
 tb/tb_gain_ctrl_48bit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gain_ctrl_48bit.sv
// Automatic gain control: finds the leading one of each frame peak and picks a right-shift for a 16-bit window.
// Latency: busy for 13 cycles after ms_in (12 nibble-scan + 1 decide); a new shift is applied on the next ms_in.
// No backpressure: ms_in arriving while busy raises overrun, drops that peak, and still loads the pending shift.
module gain_ctrl_48bit #(
   parameter int HEADROOM     = 1,
   parameter int MAX_SHIFT    = 32,
   parameter int INIT_SHIFT   = 0,
   parameter int DECAY_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ms_in,
   input  logic [47:0] max_in,
   input  logic        man_en,
   input  logic [15:0] man_coeff,
   output logic [15:0] scaled_coeff,
   output logic        coeff_valid,
   output logic [5:0]  max_msb,
   output logic        busy,
   output logic        overrun
);

   localparam int              CW      = $clog2(DECAY_FRAMES + 1);
   localparam logic [5:0]      TGT_POS = 6'(15 - HEADROOM);
   localparam logic [5:0]      MAX_S   = 6'(MAX_SHIFT);
   localparam logic [5:0]      INIT_S  = 6'(INIT_SHIFT);
   localparam logic [CW-1:0]   DECAY_N = CW'(DECAY_FRAMES);

   typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

   state_t         state_q, state_d;
   logic [47:0]    peak_q, peak_d;
   logic [3:0]     nib_q, nib_d;
   logic           found_q, found_d;
   logic [5:0]     msb_q, msb_d;
   logic [5:0]     max_msb_q, max_msb_d;
   logic           zero_q, zero_d;
   logic [5:0]     pend_q, pend_d;
   logic [CW-1:0]  dcnt_q, dcnt_d;
   logic [5:0]     scaled_q, scaled_d;
   logic           cv_q, cv_d;
   logic           busy_q, busy_d;
   logic           ovr_q, ovr_d;

   logic [3:0]     grp;
   logic [1:0]     pos;
   logic [5:0]     diff;
   logic [5:0]     target;
   logic [5:0]     man_sh;
   logic [CW-1:0]  dcnt_inc;
   logic           unused_man_hi;

   assign unused_man_hi = ^man_coeff[15:6];

   // Per-cycle helpers: current nibble, its top set bit, the candidate shift and the clamped manual shift.
   always_comb begin
      grp      = peak_q[{nib_q, 2'b00} +: 4];
      pos      = grp[3] ? 2'd3 : grp[2] ? 2'd2 : grp[1] ? 2'd1 : 2'd0;
      diff     = max_msb_q - TGT_POS;
      target   = 6'd0;
      if (!zero_q && (max_msb_q > TGT_POS)) begin
         target = (diff > MAX_S) ? MAX_S : diff;
      end
      man_sh   = (man_coeff[5:0] > MAX_S) ? MAX_S : man_coeff[5:0];
      dcnt_inc = dcnt_q + CW'(1);
   end

   // Next-state logic: frame-marker handling, nibble scan and the attack/decay decision.
   always_comb begin
      state_d   = state_q;
      peak_d    = peak_q;
      nib_d     = nib_q;
      found_d   = found_q;
      msb_d     = msb_q;
      max_msb_d = max_msb_q;
      zero_d    = zero_q;
      pend_d    = pend_q;
      dcnt_d    = dcnt_q;
      scaled_d  = scaled_q;
      cv_d      = 1'b0;
      ovr_d     = 1'b0;

      // Every frame marker applies the pending shift, whether or not a scan is running.
      if (ms_in) begin
         scaled_d = pend_q;
         cv_d     = (pend_q != scaled_q);
         ovr_d    = (state_q != IDLE);
      end

      case (state_q)
         IDLE: begin
            if (ms_in) begin
               peak_d  = max_in;
               nib_d   = 4'd11;
               found_d = 1'b0;
               msb_d   = 6'd0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            // Only the first non-zero nibble counts; later ones just burn cycles for fixed latency.
            if (!found_q && (grp != 4'd0)) begin
               found_d = 1'b1;
               msb_d   = {nib_q, pos};
            end
            if (nib_q == 4'd0) begin
               max_msb_d = found_d ? msb_d : 6'd0;
               zero_d    = !found_d;
               state_d   = DECIDE;
            end else begin
               nib_d = nib_q - 4'd1;
            end
         end
         DECIDE: begin
            if (man_en) begin
               pend_d = man_sh;
               dcnt_d = '0;
            end else if (target > pend_q) begin
               pend_d = target;
               dcnt_d = '0;
            end else if (target == pend_q) begin
               dcnt_d = '0;
            end else if (dcnt_inc == DECAY_N) begin
               pend_d = pend_q - 6'd1;
               dcnt_d = '0;
            end else begin
               dcnt_d = dcnt_inc;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset abandons any scan in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         peak_q    <= '0;
         nib_q     <= '0;
         found_q   <= 1'b0;
         msb_q     <= '0;
         max_msb_q <= '0;
         zero_q    <= 1'b0;
         pend_q    <= INIT_S;
         dcnt_q    <= '0;
         scaled_q  <= INIT_S;
         cv_q      <= 1'b0;
         busy_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         peak_q    <= peak_d;
         nib_q     <= nib_d;
         found_q   <= found_d;
         msb_q     <= msb_d;
         max_msb_q <= max_msb_d;
         zero_q    <= zero_d;
         pend_q    <= pend_d;
         dcnt_q    <= dcnt_d;
         scaled_q  <= scaled_d;
         cv_q      <= cv_d;
         busy_q    <= busy_d;
         ovr_q     <= ovr_d;
      end
   end

   assign scaled_coeff = {10'd0, scaled_q};
   assign coeff_valid  = cv_q;
   assign max_msb      = max_msb_q;
   assign busy         = busy_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_gain_ctrl_48bit.sv
// Self-checking bench for gain_ctrl_48bit: directed attack/decay/clamp/manual/reset frames plus random frames.
// Latency: each frame is followed until busy drops; the expected busy length is 13 cycles.
// Backpressure: overrun frames are injected mid-scan and their peaks must be ignored.
module tb_gain_ctrl_48bit;

   localparam int HR = 1;
   localparam int MS = 32;
   localparam int IS = 0;
   localparam int DF = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ms_in = 1'b0;
   logic [47:0] max_in = '0;
   logic        man_en = 1'b0;
   logic [15:0] man_coeff = '0;
   logic [15:0] scaled_coeff;
   logic        coeff_valid;
   logic [5:0]  max_msb;
   logic        busy;
   logic        overrun;

   int n_chk = 0;
   int n_err = 0;
   int m_scaled, m_pend, m_cnt;

   gain_ctrl_48bit #(
      .HEADROOM(HR), .MAX_SHIFT(MS), .INIT_SHIFT(IS), .DECAY_FRAMES(DF)
   ) dut (
      .clk(clk), .rst(rst), .ms_in(ms_in), .max_in(max_in),
      .man_en(man_en), .man_coeff(man_coeff),
      .scaled_coeff(scaled_coeff), .coeff_valid(coeff_valid),
      .max_msb(max_msb), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: index of the highest set bit, found by a plain bit walk.
   function automatic int ref_msb(input logic [47:0] p);
      int m = 0;
      for (int i = 0; i < 48; i++) if (p[i]) m = i;
      return m;
   endfunction

   function automatic int ref_target(input logic [47:0] p);
      int m = ref_msb(p);
      int t;
      if (p == 0 || m <= 15 - HR) return 0;
      t = m - (15 - HR);
      return (t > MS) ? MS : t;
   endfunction

   task automatic ref_decide(input logic [47:0] p, input logic me, input logic [15:0] mc);
      int t = ref_target(p);
      int mv = int'(mc[5:0]);
      if (me) begin
         m_pend = (mv > MS) ? MS : mv;
         m_cnt  = 0;
      end else if (t > m_pend) begin
         m_pend = t;
         m_cnt  = 0;
      end else if (t == m_pend) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt == DF) begin
            m_pend = m_pend - 1;
            m_cnt  = 0;
         end
      end
   endtask

   task automatic model_reset;
      m_scaled = IS;
      m_pend   = IS;
      m_cnt    = 0;
   endtask

   // One frame: marker with peak p, optional overrun marker at cycle ov_at, then gap idle cycles.
   task automatic frame(input logic [47:0] p, input logic me, input logic [15:0] mc,
                        input int ov_at, input int gap);
      int lat = 0;
      ms_in  = 1'b1;
      max_in = p;
      tick;
      ms_in  = 1'b0;
      max_in = {$urandom, $urandom};
      chk("cv_on_ms", coeff_valid, (m_pend != m_scaled));
      m_scaled = m_pend;
      chk("scaled_on_ms", scaled_coeff, m_scaled);
      chk("busy_start", busy, 1);
      man_en    = me;
      man_coeff = mc;
      for (int k = 1; k <= 20; k++) begin
         if (k == ov_at) begin
            ms_in  = 1'b1;
            max_in = {$urandom, $urandom};
         end
         tick;
         if (k == ov_at) begin
            ms_in = 1'b0;
            chk("overrun_pulse", overrun, 1);
            chk("busy_in_ovr", busy, 1);
            chk("cv_in_ovr", coeff_valid, 0);
            chk("scaled_in_ovr", scaled_coeff, m_scaled);
         end else if (overrun) begin
            chk("overrun_spurious", overrun, 0);
         end
         if (k == 12) chk("max_msb", max_msb, ref_msb(p));
         if (!busy) begin
            lat = k;
            break;
         end
      end
      chk("busy_len", lat, 13);
      chk("max_msb_hold", max_msb, ref_msb(p));
      man_en    = 1'b0;
      man_coeff = $urandom;
      ref_decide(p, me, mc);
      for (int g = 0; g < gap; g++) begin
         tick;
         if (coeff_valid || overrun) chk("idle_pulse", {coeff_valid, overrun}, 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   initial begin
      logic [63:0] r;
      logic [47:0] p;
      model_reset();

      // Reset state, during and after reset.
      repeat (3) tick;
      chk("rst_scaled", scaled_coeff, IS);
      chk("rst_cv", coeff_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_msb", max_msb, 0);
      rst = 1'b1;
      tick;
      chk("post_rst_scaled", scaled_coeff, IS);
      chk("post_rst_busy", busy, 0);

      // Peak just inside the window, then an attack to shift 18.
      frame(48'h0000_0000_7FFF, 1'b0, 16'h0, 0, 0);
      frame(48'h0001_0000_0000, 1'b0, 16'h0, 0, 1);
      frame(48'h0000_0010_0000, 1'b0, 16'h0, 0, 2);
      chk("attack_applied", scaled_coeff, 18);

      // Decay: interrupted by an equal-target frame, then four in a row.
      frame(48'h0000_0010_0000, 1'b0, 16'h0, 0, 0);
      frame(48'h0001_0000_0000, 1'b0, 16'h0, 0, 0);
      for (int i = 0; i < 4; i++) frame(48'h0000_0010_0000, 1'b0, 16'h0, 0, 0);
      chk("decay_not_yet", scaled_coeff, 18);

      // Clamp to MAX_SHIFT; this marker also applies the decayed shift.
      frame(48'h8000_0000_0000, 1'b0, 16'h0, 0, 1);
      chk("decay_applied", scaled_coeff, 17);

      // Manual override, small value and clamped value.
      frame(48'h0000_0000_0001, 1'b1, 16'h0005, 0, 0);
      chk("clamp_applied", scaled_coeff, 32);
      frame(48'h0000_0000_0000, 1'b1, 16'h0028, 0, 0);
      chk("manual_small", scaled_coeff, 5);
      frame(48'h0000_0000_0000, 1'b0, 16'h0, 0, 3);
      chk("manual_clamped", scaled_coeff, 32);

      // Asynchronous reset in the middle of a scan.
      ms_in  = 1'b1;
      max_in = 48'h0000_FFFF_0000;
      tick;
      ms_in  = 1'b0;
      repeat (4) tick;
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_scaled", scaled_coeff, IS);
      chk("arst_msb", max_msb, 0);
      chk("arst_cv", coeff_valid, 0);
      tick;
      rst = 1'b1;
      model_reset();
      tick;
      chk("arst_release_cv", coeff_valid, 0);

      // Overrun 5 cycles after a marker.
      frame(48'h0000_4000_0000, 1'b0, 16'h0, 5, 2);
      frame(48'h0000_0000_0100, 1'b0, 16'h0, 0, 0);
      chk("ovr_result_applied", scaled_coeff, 16);

      // Random frames with occasional overrun and manual override.
      for (int n = 0; n < 40; n++) begin
         r = {$urandom, $urandom};
         p = r[47:0] >> $urandom_range(0, 48);
         frame(p, ($urandom_range(0, 7) == 0), 16'($urandom),
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 12)) : 0,
               int'($urandom_range(0, 3)));
      end
      frame(48'h0, 1'b0, 16'h0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
